instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder-side counterpart of the CPU's opcode/funct control decoder.
- Accepts symbolic instruction requests (kind plus register/immediate fields) over a valid/ready handshake and encodes them into 32-bit MIPS words.
- Writes the words sequentially into instruction memory through a stallable write port.
- Used by the bench/boot path to load programs before the CPU runs. Supports R-type, addi, beq and j, matching the decoder's instruction set.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of words loadable before FULL; legal range 1 to 2**ADDR_W.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- op_kind  in  2  0=R-type, 1=ADDI, 2=BEQ, 3=J
- rs  in  5  source register
- rt  in  5  second source or destination register
- rd  in  5  R-type destination register
- funct  in  6  R-type function code
- imm  in  16  ADDI/BEQ immediate, passed through unmodified
- target  in  26  J word target
- imem_we  out  1  write strobe, held until acked
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- imem_ack  in  1  memory accepted the write this cycle
- clear  in  1  synchronous restart at address 0
- full  out  1  DEPTH words written
- err  out  1  one-cycle pulse: rejected request
- word_count  out  ADDR_W+1  words successfully written

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - state IDLE
  - in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0
  - full=0, err=0, word_count=0
- Reset has priority over all inputs, including during WRITE; a pending write is dropped.
- Encoding (instr_encode), all fields are bit-exact concatenations:
  - R: {6'b000000, rs, rt, rd, 5'b0, funct}
  - ADDI: {6'b001000, rs, rt, imm}
  - BEQ: {6'b000100, rs, rt, imm}
  - J: {6'b000010, target}
- R-type legality: funct must be one of 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other value is illegal.
- IDLE:
  - in_ready=1.
  - Legal handshake (in_valid&in_ready): register the word, go to WRITE.
  - Illegal request: err=1 for the next cycle, nothing written, stay in IDLE.
- WRITE:
  - in_ready=0, imem_we=1.
  - imem_addr and imem_wdata held stable until imem_ack.
  - On ack:
    - word_count+1 and imem_addr+1 in the same edge.
    - If the new count equals DEPTH, go to FULL and set imem_addr=0 (wrap).
    - Otherwise go to IDLE.
  - Latency: handshake at edge N; imem_we high from N+1. Zero-stall throughput is one word per 2 cycles.
- FULL:
  - full=1, in_ready=0.
  - in_valid is ignored; no err is raised.
- clear, sampled at every edge:
  - In any state: go to IDLE, imem_addr=0, word_count=0, full=0, imem_we=0.
  - In WRITE, a simultaneous imem_ack is ignored; the write counts as abandoned.
  - A request presented while clear=1 is not accepted.
- Other rules:
  - imem_ack is ignored outside WRITE.
  - err never overlaps with a write for the same request.
  - With DEPTH=1, the first ack goes directly to FULL.

Decomposition:
- Shared package cpu_isa_pkg:
  - opcode constants OP_RTYPE, OP_ADDI, OP_BEQ, OP_J
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT
  - op_kind encoding
  - loader state encoding
- The control decoder also imports cpu_isa_pkg, so both ends share one definition.
- One combinational sub-module, instr_encode: inputs are the request fields; outputs are word[31:0] and legal.
- Top level instr_encoder_loader holds the FSM, counters and handshake.

Test Plan:
- Reset, then R add rs=1 rt=2 rd=3 funct=0x20 with imem_ack tied high -> word 0x00221820 at addr 0, imem_we for 1 cycle, word_count=1.
- ADDI rs=0 rt=8 imm=5, then BEQ rs=1 rt=2 imm=0xFFFF, then J target=0x0100000, with ack delayed 3 cycles each -> 0x20080005@0, 0x1022FFFF@1, 0x08100000@2. in_ready=0 while stalled; data and address stable.
- R with funct=0x21 -> err pulses 1 cycle, no imem_we, word_count unchanged, next legal request written to addr 0.
- DEPTH=4: write 4 legal words -> full=1, imem_addr=0, in_ready=0. A further in_valid causes no write and no err. clear -> full=0, word_count=0, in_ready=1.
- Assert clear in WRITE together with imem_ack -> word_count stays 0, next request written at addr 0.
- Drive rst_n=0 for 1 cycle mid-WRITE -> all outputs at reset values on the next cycle, imem_we=0.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// ============================================================================
// Module  : cpu_isa_pkg
// Brief   : ISA constants shared by the control decoder and the program loader
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_isa_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes understood by the datapath
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  // Symbolic request kind carried on op_kind
  typedef enum logic [1:0] {
    KIND_R    = 2'd0,
    KIND_ADDI = 2'd1,
    KIND_BEQ  = 2'd2,
    KIND_J    = 2'd3
  } op_kind_e;

  // Loader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } loader_state_e;

  // True when the function code is one the decoder can execute
  function automatic logic funct_is_legal(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
           (f == F_OR)  || (f == F_SLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_loader_if.sv
// ============================================================================
// Module  : instr_encoder_loader_if
// Brief   : Request handshake and instruction-memory write port of the loader
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op_kind;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;
  logic              clear;
  logic              full;
  logic              err;
  logic [ADDR_W:0]   word_count;

  // Requester / memory side
  modport master (
    output in_valid, op_kind, rs, rt, rd, funct, imm, target, imem_ack, clear,
    input  in_ready, imem_we, imem_addr, imem_wdata, full, err, word_count
  );

  // Loader side
  modport slave (
    input  in_valid, op_kind, rs, rt, rd, funct, imm, target, imem_ack, clear,
    output in_ready, imem_we, imem_addr, imem_wdata, full, err, word_count
  );

endinterface

`default_nettype wire

// File: rtl/instr_encode.sv
// ============================================================================
// Module  : instr_encode
// Brief   : Combinational symbolic-request to 32-bit MIPS word encoder
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encode
  import cpu_isa_pkg::*;
(
  input  wire logic [1:0]  i_op_kind,
  input  wire logic [4:0]  i_rs,
  input  wire logic [4:0]  i_rt,
  input  wire logic [4:0]  i_rd,
  input  wire logic [5:0]  i_funct,
  input  wire logic [15:0] i_imm,
  input  wire logic [25:0] i_target,
  output logic      [31:0] o_word,
  output logic             o_legal
);

  // Field concatenation per instruction format; only R-type can be illegal
  always_comb begin
    o_word  = '0;
    o_legal = 1'b1;
    case (op_kind_e'(i_op_kind))
      KIND_R: begin
        o_word  = {OP_RTYPE, i_rs, i_rt, i_rd, 5'b00000, i_funct};
        o_legal = funct_is_legal(i_funct);
      end
      KIND_ADDI: o_word = {OP_ADDI, i_rs, i_rt, i_imm};
      KIND_BEQ:  o_word = {OP_BEQ, i_rs, i_rt, i_imm};
      KIND_J:    o_word = {OP_J, i_target};
      default:   o_word = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
// Module  : instr_encoder_loader
// Brief   : Encodes instruction requests and writes them sequentially into
//           instruction memory over a stallable write port
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  instr_encoder_loader_if.slave bus
);

  localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

  loader_state_e     r_state;
  logic              r_in_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_full;
  logic              r_err;
  logic [ADDR_W:0]   r_word_count;

  logic [31:0]       w_word;
  logic              w_legal;
  logic [ADDR_W:0]   w_count_next;

  instr_encode u_encode (
    .i_op_kind (bus.op_kind),
    .i_rs      (bus.rs),
    .i_rt      (bus.rt),
    .i_rd      (bus.rd),
    .i_funct   (bus.funct),
    .i_imm     (bus.imm),
    .i_target  (bus.target),
    .o_word    (w_word),
    .o_legal   (w_legal)
  );

  assign w_count_next = r_word_count + c_CNT_ONE;

  // Loader FSM: accept in IDLE, hold the write until acked, park in FULL.
  // Clear overrides everything but reset; a concurrent ack is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b1;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_err <= 1'b0;
      if (bus.clear) begin
        r_state      <= ST_IDLE;
        r_in_ready   <= 1'b1;
        r_imem_we    <= 1'b0;
        r_imem_addr  <= '0;
        r_full       <= 1'b0;
        r_word_count <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.in_valid) begin
              if (w_legal) begin
                r_imem_wdata <= w_word;
                r_imem_we    <= 1'b1;
                r_in_ready   <= 1'b0;
                r_state      <= ST_WRITE;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_WRITE: begin
            if (bus.imem_ack) begin
              r_imem_we    <= 1'b0;
              r_word_count <= w_count_next;
              if (w_count_next == c_DEPTH) begin
                r_imem_addr <= '0;
                r_full      <= 1'b1;
                r_in_ready  <= 1'b0;
                r_state     <= ST_FULL;
              end else begin
                r_imem_addr <= r_imem_addr + c_ADDR_ONE;
                r_in_ready  <= 1'b1;
                r_state     <= ST_IDLE;
              end
            end
          end
          ST_FULL: begin
            r_in_ready <= 1'b0;
          end
          default: begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
            r_imem_we  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.full       = r_full;
  assign bus.err        = r_err;
  assign bus.word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// Module  : tb_instr_encoder_loader
// Brief   : Self-checking bench for instr_encoder_loader (DEPTH=4 build)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: words written and next address
  int m_count = 0;
  int m_addr  = 0;

  // Instruction word built from the format rules with plain arithmetic
  function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                           input int rd, input int funct, input int imm,
                                           input int target);
    longint v;
    case (kind)
      0:       v = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + funct;
      1:       v = 64'h2000_0000 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      2:       v = 64'h1000_0000 + rs * 64'd2097152 + rt * 64'd65536 + imm;
      default: v = 64'h0800_0000 + target;
    endcase
    return v[31:0];
  endfunction

  function automatic bit ref_legal(input int kind, input int funct);
    return (kind != 0) || (funct == 32) || (funct == 34) || (funct == 36) ||
           (funct == 37) || (funct == 42);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int kind, input int rs, input int rt, input int rd,
                            input int funct, input int imm, input int target);
    bus.op_kind = 2'(kind);
    bus.rs      = 5'(rs);
    bus.rt      = 5'(rt);
    bus.rd      = 5'(rd);
    bus.funct   = 6'(funct);
    bus.imm     = 16'(imm);
    bus.target  = 26'(target);
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_word_count", 32'(bus.word_count), 32'd0);
  endtask

  // One request through handshake, optional stall, and ack
  task automatic do_req(input int kind, input int rs, input int rt, input int rd,
                        input int funct, input int imm, input int target, input int delay);
    logic [31:0] w;
    w = ref_word(kind, rs, rt, rd, funct, imm, target);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    set_fields(kind, rs, rt, rd, funct, imm, target);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (ref_legal(kind, funct)) begin
      chk("we_on", 32'(bus.imem_we), 32'd1);
      chk("addr", 32'(bus.imem_addr), 32'(m_addr));
      chk("wdata", bus.imem_wdata, w);
      chk("in_ready_write", 32'(bus.in_ready), 32'd0);
      chk("err_on_write", 32'(bus.err), 32'd0);
      repeat (delay) begin
        @(posedge clk);
        @(negedge clk);
        chk("we_stall", 32'(bus.imem_we), 32'd1);
        chk("addr_stable", 32'(bus.imem_addr), 32'(m_addr));
        chk("wdata_stable", bus.imem_wdata, w);
        chk("in_ready_stall", 32'(bus.in_ready), 32'd0);
      end
      bus.imem_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.imem_ack = 0;
      m_count++;
      m_addr = (m_count == DEPTH) ? 0 : m_addr + 1;
      chk("we_off", 32'(bus.imem_we), 32'd0);
      chk("word_count", 32'(bus.word_count), 32'(m_count));
      chk("addr_next", 32'(bus.imem_addr), 32'(m_addr));
      chk("full", 32'(bus.full), 32'(m_count == DEPTH));
      chk("in_ready_after", 32'(bus.in_ready), 32'(m_count != DEPTH));
    end else begin
      chk("err_pulse", 32'(bus.err), 32'd1);
      chk("we_illegal", 32'(bus.imem_we), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("err_end", 32'(bus.err), 32'd0);
      chk("count_illegal", 32'(bus.word_count), 32'(m_count));
      chk("we_illegal2", 32'(bus.imem_we), 32'd0);
    end
  endtask

  task automatic rand_req(input bit allow_illegal, input int delay);
    int legal_f[5];
    int kind;
    int funct;
    legal_f = '{32, 34, 36, 37, 42};
    kind  = int'($urandom_range(0, 3));
    funct = legal_f[$urandom_range(0, 4)];
    if (allow_illegal && ($urandom_range(0, 3) == 0)) funct = int'($urandom_range(0, 63));
    do_req(kind, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), funct, int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 67108863)), delay);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b0;
    m_count = 0;
    m_addr  = 0;
    chk("clr_count", 32'(bus.word_count), 32'd0);
    chk("clr_addr", 32'(bus.imem_addr), 32'd0);
    chk("clr_full", 32'(bus.full), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_we", 32'(bus.imem_we), 32'd0);
  endtask

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.imem_ack = 1'b0;
    bus.clear    = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // Basic R-type add with immediate ack
    do_req(0, 1, 2, 3, 'h20, 0, 0, 0);
    do_clear();

    // Stalled writes of ADDI, BEQ, J
    do_req(1, 0, 8, 0, 0, 5, 0, 3);
    do_req(2, 1, 2, 0, 0, 'hFFFF, 0, 3);
    do_req(3, 0, 0, 0, 0, 0, 'h0100000, 3);
    do_clear();

    // Illegal funct rejected, next legal request goes to address 0
    do_req(0, 1, 2, 3, 'h21, 0, 0, 0);
    rand_req(1'b0, 1);

    // Fill to DEPTH, then requests are ignored without err
    while (m_count < DEPTH) rand_req(1'b0, int'($urandom_range(0, 2)));
    @(negedge clk);
    set_fields(1, 3, 4, 0, 0, 7, 0);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("full_no_we", 32'(bus.imem_we), 32'd0);
      chk("full_no_err", 32'(bus.err), 32'd0);
      chk("full_count", 32'(bus.word_count), 32'(DEPTH));
      chk("full_flag", 32'(bus.full), 32'd1);
    end
    bus.in_valid = 1'b0;
    do_clear();

    // Request presented with clear is not accepted
    @(negedge clk);
    set_fields(0, 5, 6, 7, 'h22, 0, 0);
    bus.in_valid = 1'b1;
    bus.clear    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    chk("clrreq_we", 32'(bus.imem_we), 32'd0);
    chk("clrreq_err", 32'(bus.err), 32'd0);
    chk("clrreq_ready", 32'(bus.in_ready), 32'd1);

    // Ack outside WRITE is ignored
    bus.imem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("idle_ack_count", 32'(bus.word_count), 32'd0);
    chk("idle_ack_addr", 32'(bus.imem_addr), 32'd0);

    // Clear in WRITE together with ack abandons the write
    @(negedge clk);
    set_fields(1, 2, 3, 0, 0, 'h1234, 0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("cw_we_on", 32'(bus.imem_we), 32'd1);
    bus.clear    = 1'b1;
    bus.imem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clear    = 1'b0;
    bus.imem_ack = 1'b0;
    chk("cw_count", 32'(bus.word_count), 32'd0);
    chk("cw_we_off", 32'(bus.imem_we), 32'd0);
    chk("cw_addr", 32'(bus.imem_addr), 32'd0);
    m_count = 0;
    m_addr  = 0;
    rand_req(1'b0, 0);

    // Reset mid-WRITE drops the pending write
    @(negedge clk);
    set_fields(3, 0, 0, 0, 0, 0, 'h2ABCDEF);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rw_we_on", 32'(bus.imem_we), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_vals();
    m_count = 0;
    m_addr  = 0;

    // Randomised mix including illegal requests and varied stalls
    repeat (24) begin
      if (m_count == DEPTH) do_clear();
      rand_req(1'b1, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
